id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register with load-use hazard detection for the five-stage MIPS pipeline. Sits between the decoder and the EX stage, capturing decoded operands and control, and presents rs_EX, rt_EX, ALUSrcA_EX and ALUSrcB_EX to the EX-stage forwarding mux-select logic. Inserts a one-cycle bubble and stalls IF/ID when an instruction in ID needs a load result still in EX. Squashes ID on a taken branch/jump flush.

## Interface
- No parameters; datapath fixed at 32 bits, register index at 5 bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  taken branch/jump resolved; squash the instruction in ID
- rs_ID, rt_ID, Rw_ID  in  5 each  source/destination register indices
- use_rs_ID, use_rt_ID  in  1 each  instruction actually reads rs/rt
- RegWrite_ID, MemRead_ID, MemWrite_ID, ALUSrcA_ID, ALUSrcB_ID  in  1 each  control
- MemtoReg_ID  in  2  writeback select
- ALUCtrl_ID  in  5  ALU operation
- dataA_ID, dataB_ID, Imm_ID, PC_ID  in  32 each  register-file read data, extended immediate, PC+4
- Shamt_ID  in  5  shift amount
- (all of the above *_ID signals) mirrored as *_EX outputs, same widths, registered
- valid_EX  out  1  EX slot holds a real instruction (0 = bubble)
- stall  out  1  combinational; hold PC and IF/ID this cycle
- stall_cnt, bubble_cnt  out  32 each  present only with ID_EX_PERF_CNT_EN

## Operation
- Hazard condition `hz` = MemRead_EX & RegWrite_EX & valid_EX & (Rw_EX != 0) & ((use_rs_ID & Rw_EX == rs_ID) | (use_rt_ID & Rw_EX == rt_ID)).
- stall = hz & ~flush. Flush has priority because the ID instruction is discarded anyway.
- Each rising edge takes exactly one action, in priority order:
  1. flush = 1: load a bubble.
  2. hz = 1: load a bubble; the ID instruction stays in ID because of the stall.
  3. Otherwise: capture every *_ID field into *_EX and set valid_EX = 1.
- Bubble means every *_EX field is 0 and valid_EX = 0, so RegWrite_EX = MemRead_EX = MemWrite_EX = 0 and Rw_EX = 0.
- One stall cycle suffices. After the bubble, the load is in WB and the EX-stage WB forwarding path supplies its data. In the next cycle MemRead_EX = 0, so hz deasserts without further state.
- Back-to-back load → dependent instruction → dependent instruction: only the first pair stalls.
- Implicit state machine on valid_EX/MemRead_EX:
  - RUN → BUBBLE on flush or hz.
  - BUBBLE → RUN on the next non-flush edge.

## Timing
- Register latency: *_ID to *_EX is 1 cycle.
- stall is combinational from the current-cycle *_ID inputs and the registered *_EX state. There is no register on stall.
- Reset (asynchronous): all *_EX = 0, valid_EX = 0, and counters = 0. stall therefore reads 0 immediately.
- Reset asserted mid-stall: the bubble is forced regardless of flush or hz, and stall drops within the same cycle.
- flush and hz in the same cycle: bubble, stall = 0, bubble_cnt increments by 1 and stall_cnt does not.
- Rw_EX = 0 never stalls, even for a load to $0.

## Configuration
- `ID_EX_PERF_CNT_EN` defined:
  - stall_cnt increments on every edge where stall = 1.
  - bubble_cnt increments on every edge where a bubble is loaded (flush or hz).
  - Both are 32-bit, wrap modulo 2^32, reset to 0, and are read-only.
- Not defined: both ports and their counters are absent; behaviour is otherwise identical.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle with MemRead_EX = 1 → all *_EX = 0, valid_EX = 0 and stall = 0 before the next edge.
- **Load-use on rs:** `lw $8,0($9)` followed by `add $10,$8,$11` with use_rs_ID = 1 → stall = 1 for exactly 1 cycle. The next EX slot is a bubble (valid_EX = 0, RegWrite_EX = 0), then the add enters EX with rs_EX = 8.
- **No false stall:**
  - lw to $0 followed by an instruction reading $0 → stall = 0.
  - lw $8 followed by an instruction with rt_ID = 8 and use_rt_ID = 0 (I-type) → stall = 0.
- **Flush priority:** hz true and flush = 1 in the same cycle → stall = 0 and the EX slot becomes a bubble. With ID_EX_PERF_CNT_EN, bubble_cnt goes 0→1 and stall_cnt stays 0.
- **Normal flow:** 5 independent ALU instructions back-to-back → each appears on *_EX exactly one cycle later, valid_EX = 1 throughout, stall never asserted.
- **Counter wrap (ID_EX_PERF_CNT_EN):** force stall_cnt to 32'hFFFFFFFF, then create one load-use stall → stall_cnt = 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register for the five-stage MIPS pipeline, with load-use
// hazard detection and flush squashing.
//
// Every rising edge loads exactly one of the following into the EX slot:
//   - a bubble, when flush is high (the ID instruction is being discarded)
//   - a bubble, when a load in EX feeds the ID instruction (load-use hazard).
//     In this case stall holds PC and IF/ID so the ID instruction retries.
//   - the decoded ID instruction, otherwise (valid_EX = 1).
// A bubble is all *_EX fields zero with valid_EX = 0. The state is therefore
// RUN when valid_EX = 1 and BUBBLE when valid_EX = 0.
//
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   flush           taken branch/jump: squash the instruction in ID
//   *_ID            decoded operands and control from the ID stage
//   *_EX            registered copies of *_ID, presented to the EX stage
//   valid_EX        EX slot holds a real instruction (0 = bubble)
//   stall           combinational: hold PC and IF/ID this cycle
//   stall_cnt       edges on which stall was high      (ID_EX_PERF_CNT_EN)
//   bubble_cnt      edges on which a bubble was loaded (ID_EX_PERF_CNT_EN)
//
// Optional feature macro: ID_EX_PERF_CNT_EN adds the two 32-bit wrapping
// performance counters and their output ports.
// ---------------------------------------------------------------------------
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic [4:0]  Rw_ID,
    input  logic        use_rs_ID,
    input  logic        use_rt_ID,
    input  logic        RegWrite_ID,
    input  logic        MemRead_ID,
    input  logic        MemWrite_ID,
    input  logic        ALUSrcA_ID,
    input  logic        ALUSrcB_ID,
    input  logic [1:0]  MemtoReg_ID,
    input  logic [4:0]  ALUCtrl_ID,
    input  logic [31:0] dataA_ID,
    input  logic [31:0] dataB_ID,
    input  logic [31:0] Imm_ID,
    input  logic [31:0] PC_ID,
    input  logic [4:0]  Shamt_ID,
    output logic [4:0]  rs_EX,
    output logic [4:0]  rt_EX,
    output logic [4:0]  Rw_EX,
    output logic        use_rs_EX,
    output logic        use_rt_EX,
    output logic        RegWrite_EX,
    output logic        MemRead_EX,
    output logic        MemWrite_EX,
    output logic        ALUSrcA_EX,
    output logic        ALUSrcB_EX,
    output logic [1:0]  MemtoReg_EX,
    output logic [4:0]  ALUCtrl_EX,
    output logic [31:0] dataA_EX,
    output logic [31:0] dataB_EX,
    output logic [31:0] Imm_EX,
    output logic [31:0] PC_EX,
    output logic [4:0]  Shamt_EX,
    output logic        valid_EX,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        stall
);

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic        use_rs;
        logic        use_rt;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [1:0]  mem_to_reg;
        logic [4:0]  alu_ctrl;
        logic [31:0] data_a;
        logic [31:0] data_b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  shamt;
    } stage_fields_t;

    stage_fields_t id_fields;
    stage_fields_t ex_d, ex_q;
    logic          valid_d, valid_q;
    logic          hz;
    logic          load_bubble;

    assign id_fields = '{
        rs:         rs_ID,
        rt:         rt_ID,
        rw:         Rw_ID,
        use_rs:     use_rs_ID,
        use_rt:     use_rt_ID,
        reg_write:  RegWrite_ID,
        mem_read:   MemRead_ID,
        mem_write:  MemWrite_ID,
        alu_src_a:  ALUSrcA_ID,
        alu_src_b:  ALUSrcB_ID,
        mem_to_reg: MemtoReg_ID,
        alu_ctrl:   ALUCtrl_ID,
        data_a:     dataA_ID,
        data_b:     dataB_ID,
        imm:        Imm_ID,
        pc:         PC_ID,
        shamt:      Shamt_ID
    };

    // A load in EX whose destination is read by the ID instruction. $0 is
    // never a real dependency. One bubble is enough: afterwards the load is
    // in WB and the forwarding path covers it, and MemRead_EX is 0 so hz
    // clears without extra state.
    assign hz = ex_q.mem_read & ex_q.reg_write & valid_q & (ex_q.rw != 5'd0) &
                ((use_rs_ID & (ex_q.rw == rs_ID)) | (use_rt_ID & (ex_q.rw == rt_ID)));

    // Flush wins: the ID instruction is discarded, so holding it is pointless.
    assign stall       = hz & ~flush;
    assign load_bubble = flush | hz;

    always_comb begin
        ex_d    = id_fields;
        valid_d = 1'b1;
        if (load_bubble) begin
            ex_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ex_q    <= ex_d;
            valid_q <= valid_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Both counters wrap naturally modulo 2^32.
    assign stall_cnt_d  = stall_cnt_q + {31'd0, stall};
    assign bubble_cnt_d = bubble_cnt_q + {31'd0, load_bubble};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

    assign rs_EX       = ex_q.rs;
    assign rt_EX       = ex_q.rt;
    assign Rw_EX       = ex_q.rw;
    assign use_rs_EX   = ex_q.use_rs;
    assign use_rt_EX   = ex_q.use_rt;
    assign RegWrite_EX = ex_q.reg_write;
    assign MemRead_EX  = ex_q.mem_read;
    assign MemWrite_EX = ex_q.mem_write;
    assign ALUSrcA_EX  = ex_q.alu_src_a;
    assign ALUSrcB_EX  = ex_q.alu_src_b;
    assign MemtoReg_EX = ex_q.mem_to_reg;
    assign ALUCtrl_EX  = ex_q.alu_ctrl;
    assign dataA_EX    = ex_q.data_a;
    assign dataB_EX    = ex_q.data_b;
    assign Imm_EX      = ex_q.imm;
    assign PC_EX       = ex_q.pc;
    assign Shamt_EX    = ex_q.shamt;
    assign valid_EX    = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed scenarios (reset, load-use, no false stall, flush priority,
// normal flow, counter wrap) followed by randomized traffic, all checked
// against a behavioural model of the pipeline slot kept in this file.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rw;
        logic        use_rs;
        logic        use_rt;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src_a;
        logic        alu_src_b;
        logic [1:0]  mem_to_reg;
        logic [4:0]  alu_ctrl;
        logic [31:0] data_a;
        logic [31:0] data_b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  shamt;
    } instr_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    instr_t id = '0;
    instr_t ex_obs;

    logic [4:0]  rs_EX, rt_EX, Rw_EX, ALUCtrl_EX, Shamt_EX;
    logic        use_rs_EX, use_rt_EX, RegWrite_EX, MemRead_EX, MemWrite_EX;
    logic        ALUSrcA_EX, ALUSrcB_EX, valid_EX, stall;
    logic [1:0]  MemtoReg_EX;
    logic [31:0] dataA_EX, dataB_EX, Imm_EX, PC_EX;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    id_ex_stage dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .rs_ID       (id.rs),
        .rt_ID       (id.rt),
        .Rw_ID       (id.rw),
        .use_rs_ID   (id.use_rs),
        .use_rt_ID   (id.use_rt),
        .RegWrite_ID (id.reg_write),
        .MemRead_ID  (id.mem_read),
        .MemWrite_ID (id.mem_write),
        .ALUSrcA_ID  (id.alu_src_a),
        .ALUSrcB_ID  (id.alu_src_b),
        .MemtoReg_ID (id.mem_to_reg),
        .ALUCtrl_ID  (id.alu_ctrl),
        .dataA_ID    (id.data_a),
        .dataB_ID    (id.data_b),
        .Imm_ID      (id.imm),
        .PC_ID       (id.pc),
        .Shamt_ID    (id.shamt),
        .rs_EX       (rs_EX),
        .rt_EX       (rt_EX),
        .Rw_EX       (Rw_EX),
        .use_rs_EX   (use_rs_EX),
        .use_rt_EX   (use_rt_EX),
        .RegWrite_EX (RegWrite_EX),
        .MemRead_EX  (MemRead_EX),
        .MemWrite_EX (MemWrite_EX),
        .ALUSrcA_EX  (ALUSrcA_EX),
        .ALUSrcB_EX  (ALUSrcB_EX),
        .MemtoReg_EX (MemtoReg_EX),
        .ALUCtrl_EX  (ALUCtrl_EX),
        .dataA_EX    (dataA_EX),
        .dataB_EX    (dataB_EX),
        .Imm_EX      (Imm_EX),
        .PC_EX       (PC_EX),
        .Shamt_EX    (Shamt_EX),
        .valid_EX    (valid_EX),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt),
`endif
        .stall       (stall)
    );

    assign ex_obs = '{rs_EX, rt_EX, Rw_EX, use_rs_EX, use_rt_EX, RegWrite_EX,
                      MemRead_EX, MemWrite_EX, ALUSrcA_EX, ALUSrcB_EX,
                      MemtoReg_EX, ALUCtrl_EX, dataA_EX, dataB_EX, Imm_EX,
                      PC_EX, Shamt_EX};

    // ---------------- scoreboard / checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [161:0] got, input logic [161:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: what the EX slot should hold, and the counters.
    instr_t      m_ex = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_bubble_cnt = '0;

    // A load currently in EX produces a register the ID instruction reads.
    function automatic logic model_hazard(input instr_t in);
        logic producer_is_load;
        logic reads_it;
        producer_is_load = m_valid && m_ex.mem_read && m_ex.reg_write && (m_ex.rw != 0);
        reads_it = (in.use_rs && in.rs == m_ex.rw) || (in.use_rt && in.rt == m_ex.rw);
        return producer_is_load && reads_it;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.rs         = 5'($urandom_range(0, 3));
        t.rt         = 5'($urandom_range(0, 3));
        t.rw         = 5'($urandom_range(0, 3));
        t.use_rs     = 1'($urandom_range(0, 1));
        t.use_rt     = 1'($urandom_range(0, 1));
        t.reg_write  = ($urandom_range(0, 3) != 0);
        t.mem_read   = 1'($urandom_range(0, 1));
        t.mem_write  = 1'($urandom_range(0, 1));
        t.alu_src_a  = 1'($urandom_range(0, 1));
        t.alu_src_b  = 1'($urandom_range(0, 1));
        t.mem_to_reg = 2'($urandom_range(0, 3));
        t.alu_ctrl   = 5'($urandom_range(0, 31));
        t.data_a     = $urandom;
        t.data_b     = $urandom;
        t.imm        = $urandom;
        t.pc         = $urandom;
        t.shamt      = 5'($urandom_range(0, 31));
        return t;
    endfunction

    function automatic instr_t make_instr(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rw, input logic urs,
                                          input logic urt, input logic load);
        instr_t t;
        t           = rand_instr();
        t.rs        = rs;
        t.rt        = rt;
        t.rw        = rw;
        t.use_rs    = urs;
        t.use_rt    = urt;
        t.reg_write = 1'b1;
        t.mem_read  = load;
        t.mem_write = 1'b0;
        return t;
    endfunction

    // ---------------- driver ----------------
    // Entered just after a rising edge. Drives one cycle, checks stall before
    // the edge and the EX slot after it.
    task automatic step(input instr_t in, input logic fl);
        logic hz;
        logic bub;
        id    = in;
        flush = fl;
        @(negedge clk);
        hz = model_hazard(in);
        check("stall", {161'd0, stall}, {161'd0, hz & ~fl});
        @(posedge clk);
        bub = fl | hz;
        if (hz && !fl) m_stall_cnt = m_stall_cnt + 1;
        if (bub) m_bubble_cnt = m_bubble_cnt + 1;
        m_ex    = bub ? '0 : in;
        m_valid = ~bub;
        #1;
        check("ex_fields", ex_obs, m_ex);
        check("valid_EX", {161'd0, valid_EX}, {161'd0, m_valid});
`ifdef ID_EX_PERF_CNT_EN
        check("stall_cnt", {130'd0, stall_cnt}, {130'd0, m_stall_cnt});
        check("bubble_cnt", {130'd0, bubble_cnt}, {130'd0, m_bubble_cnt});
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        instr_t lw8, dep;
        // ---- reset ----
        id = rand_instr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ex", ex_obs, '0);
        check("rst_valid", {161'd0, valid_EX}, '0);
        check("rst_stall", {161'd0, stall}, '0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // the edge after reset release captured id as an instruction
        m_ex = id; m_valid = 1'b1;
        check("post_rst_ex", ex_obs, m_ex);

        // ---- load-use on rs: lw $8,0($9) ; add $10,$8,$11 ----
        step(make_instr(5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0), 1'b0);
        lw8 = make_instr(5'd9, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1);
        dep = make_instr(5'd8, 5'd11, 5'd10, 1'b1, 1'b1, 1'b0);
        step(lw8, 1'b0);
        step(dep, 1'b0);                 // stall, bubble enters EX
        check("lu_bubble_valid", {161'd0, valid_EX}, '0);
        check("lu_bubble_regwr", {161'd0, RegWrite_EX}, '0);
        step(dep, 1'b0);                 // add now enters EX
        check("lu_rs_EX", {157'd0, rs_EX}, {157'd0, 5'd8});

        // ---- no false stall: load to $0, then reader of $0 ----
        step(make_instr(5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1), 1'b0);
        step(make_instr(5'd0, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0), 1'b0);
        // ---- no false stall: rt matches but is not read ----
        step(lw8, 1'b0);
        step(make_instr(5'd3, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0), 1'b0);

        // ---- back-to-back: lw -> dep -> dep, only first pair stalls ----
        step(lw8, 1'b0);
        step(dep, 1'b0);
        step(dep, 1'b0);
        step(make_instr(5'd10, 5'd8, 5'd12, 1'b1, 1'b1, 1'b0), 1'b0);

        // ---- flush priority: hazard and flush together ----
        step(lw8, 1'b0);
        step(dep, 1'b1);
        check("flush_valid", {161'd0, valid_EX}, '0);

        // ---- normal flow: 5 independent ALU ops ----
        for (int i = 0; i < 5; i++)
            step(make_instr(5'(20 + i), 5'(25 + i), 5'(14 + i), 1'b1, 1'b1, 1'b0), 1'b0);

        // ---- reset asserted mid-stall ----
        step(lw8, 1'b0);
        id = dep;
        @(negedge clk);
        check("pre_rst_stall", {161'd0, stall}, {161'd0, 1'b1});
        #1 reset = 1'b1;
        #1;
        check("mid_rst_stall", {161'd0, stall}, '0);
        check("mid_rst_ex", ex_obs, '0);
        check("mid_rst_valid", {161'd0, valid_EX}, '0);
        #1 reset = 1'b0;
        m_ex = '0; m_valid = 1'b0; m_stall_cnt = '0; m_bubble_cnt = '0;
        @(posedge clk);
        #1;
        m_ex = dep; m_valid = 1'b1;
        check("post_mid_rst_ex", ex_obs, m_ex);

`ifdef ID_EX_PERF_CNT_EN
        // ---- counter wrap ----
        step(make_instr(5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0), 1'b0);
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        m_stall_cnt = 32'hFFFF_FFFF;
        step(lw8, 1'b0);
        step(dep, 1'b0);
        check("stall_cnt_wrap", {130'd0, stall_cnt}, '0);
`endif

        // ---- randomized traffic ----
        for (int i = 0; i < 400; i++)
            step(rand_instr(), ($urandom_range(0, 7) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
